// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator: operation encodings and
// signed range limits for a given data width.
package accum_pkg;

  // Operation selector carried alongside each operand.
  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  // Widest data path the range helpers can describe.
  localparam int MAX_WIDTH = 64;

  // Largest positive two's-complement value of the given width,
  // right-aligned in a MAX_WIDTH vector (0x7F.. pattern).
  function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = (64'd1 << (width - 32'sd1)) - 64'd1;
    return v;
  endfunction

  // Most negative two's-complement value of the given width,
  // right-aligned in a MAX_WIDTH vector (0x80.. pattern).
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = 64'd1 << (width - 32'sd1);
    return v;
  endfunction

  // True for the operations that fold an operand into the running total
  // and therefore advance the sample counter.
  function automatic logic op_counts(input op_e op);
    logic r;
    case (op)
      OP_ADD:  r = 1'b1;
      OP_SUB:  r = 1'b1;
      OP_LOAD: r = 1'b0;
      OP_CLR:  r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/accum_addsub.sv
// Combinational arithmetic core of the accumulator. Produces the raw
// (wrapping) result, the optionally clamped result, carry/borrow and
// signed overflow for one operation on acc and a. The same instance
// feeds both the LED preview and the stage-2 register update.
module accum_addsub
  import accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r_raw,
  output logic [WIDTH-1:0] r_sat,
  output logic             c,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  op_e            op_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic           acc_sign_s;
  logic           a_sign_s;

  assign op_s       = op_e'(op);
  // One extra bit on each side so the MSB of the result is carry-out
  // for the sum and unsigned borrow for the difference.
  assign sum_s      = {1'b0, acc} + {1'b0, a};
  assign diff_s     = {1'b0, acc} - {1'b0, a};
  assign acc_sign_s = acc[WIDTH-1];
  assign a_sign_s   = a[WIDTH-1];

  // Select the raw result, carry and overflow for the requested operation.
  always_comb begin
    r_raw = ZERO;
    c     = 1'b0;
    ovf   = 1'b0;
    case (op_s)
      OP_ADD: begin
        r_raw = sum_s[WIDTH-1:0];
        c     = sum_s[WIDTH];
        ovf   = (acc_sign_s == a_sign_s) && (sum_s[WIDTH-1] != acc_sign_s);
      end
      OP_SUB: begin
        r_raw = diff_s[WIDTH-1:0];
        c     = diff_s[WIDTH];
        ovf   = (acc_sign_s != a_sign_s) && (diff_s[WIDTH-1] != acc_sign_s);
      end
      OP_LOAD: begin
        r_raw = a;
        c     = 1'b0;
        ovf   = 1'b0;
      end
      OP_CLR: begin
        r_raw = ZERO;
        c     = 1'b0;
        ovf   = 1'b0;
      end
      default: begin
        r_raw = ZERO;
        c     = 1'b0;
        ovf   = 1'b0;
      end
    endcase
  end

  // Clamp toward the side the accumulator was on when the result overflowed;
  // in wrap mode the raw result passes through untouched.
  always_comb begin
    r_sat = r_raw;
    if ((SATURATE != 0) && ovf) begin
      if (acc_sign_s) begin
        r_sat = SMIN;
      end else begin
        r_sat = SMAX;
      end
    end else begin
      r_sat = r_raw;
    end
  end

endmodule

// File: rtl/accum_unit.sv
// Two-stage accumulator. Stage 1 registers the operand and operation;
// stage 2 folds it into the running total with add, subtract, load or
// clear, tracks carry/overflow, a sticky overflow flag and a saturating
// count of folded samples. preview shows the unclamped result the
// pending operation would produce, for the LED display.
module accum_unit
  import accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] preview,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Stage-1 state
  logic s1_v_r;
  op_e  op_r;

  // Arithmetic results for the pending operation
  logic [WIDTH-1:0] r_raw_s;
  logic [WIDTH-1:0] r_sat_s;
  logic             c_s;
  logic             ovf_s;

  // Stage-2 next-state values
  logic [WIDTH-1:0] acc_nxt_s;
  logic             carry_nxt_s;
  logic             ovf_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             sticky_nxt_s;
  logic             valid_nxt_s;

  accum_addsub #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_addsub (
    .acc   (acc_out),
    .a     (a_reg),
    .op    (op_r),
    .r_raw (r_raw_s),
    .r_sat (r_sat_s),
    .c     (c_s),
    .ovf   (ovf_s)
  );

  assign preview = r_raw_s;

  // Stage 1: capture operand and operation when offered; the operand
  // register doubles as the display copy, so it holds while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v_r <= 1'b0;
      a_reg  <= ZERO_W;
      op_r   <= OP_ADD;
    end else begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        a_reg <= in;
        op_r  <= op_e'(op);
      end else begin
        a_reg <= a_reg;
        op_r  <= op_r;
      end
    end
  end

  // Stage 2 next state: apply the pending operation when stage 1 holds one,
  // otherwise hold everything and drop the completion pulse.
  always_comb begin
    acc_nxt_s   = acc_out;
    carry_nxt_s = carry;
    ovf_nxt_s   = overflow;
    count_nxt_s = count;
    valid_nxt_s = 1'b0;
    if (s1_v_r) begin
      acc_nxt_s   = r_sat_s;
      carry_nxt_s = c_s;
      ovf_nxt_s   = ovf_s;
      valid_nxt_s = 1'b1;
      case (op_r)
        OP_ADD, OP_SUB: begin
          if (op_counts(op_r) && (count != CNT_MAX)) begin
            count_nxt_s = count + CNT_ONE;
          end else begin
            count_nxt_s = count;
          end
        end
        OP_LOAD: count_nxt_s = CNT_ONE;
        OP_CLR:  count_nxt_s = CNT_ZERO;
        default: count_nxt_s = count;
      endcase
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // Sticky overflow: a fresh overflow beats a simultaneous clear request;
  // a CLR operation can never overflow, so it always leaves the flag low.
  always_comb begin
    sticky_nxt_s = ovf_sticky;
    if (s1_v_r && ovf_s) begin
      sticky_nxt_s = 1'b1;
    end else if (s1_v_r && (op_r == OP_CLR)) begin
      sticky_nxt_s = 1'b0;
    end else if (ovf_clr) begin
      sticky_nxt_s = 1'b0;
    end else begin
      sticky_nxt_s = ovf_sticky;
    end
  end

  // Stage 2 registers; reset discards any operand still in stage 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_out    <= ZERO_W;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      count      <= CNT_ZERO;
      out_valid  <= 1'b0;
    end else begin
      acc_out    <= acc_nxt_s;
      carry      <= carry_nxt_s;
      overflow   <= ovf_nxt_s;
      ovf_sticky <= sticky_nxt_s;
      count      <= count_nxt_s;
      out_valid  <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_accum_unit.sv
// Self-checking bench for accum_unit. Three instances share one stimulus
// stream: wrap mode, saturate mode, and a 2-bit counter. Expected results
// are computed when an operation is driven and queued per instance, then
// popped on the edge where the result is due.
module tb_accum_unit;
  import accum_pkg::*;

  typedef struct packed {
    logic       v;
    logic [1:0] o;
    logic [7:0] d;
    logic       clr;
    logic       rs;
  } stim_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] acc;
    logic       c;
    logic       ovf;
    logic [7:0] cnt;
  } ent_t;

  typedef struct packed {
    logic       ov;
    logic [7:0] a;
    logic [7:0] acc;
    logic       c;
    logic       ovf;
    logic       st;
    logic [7:0] cnt;
    logic [7:0] pv;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] din = 8'd0;

  logic [7:0] a0, acc0, pv0, cnt0;
  logic       v0, c0, ovf0, st0;
  logic [7:0] a1, acc1, pv1, cnt1;
  logic       v1, c1, ovf1, st1;
  logic [7:0] a2, acc2, pv2;
  logic [1:0] cnt2;
  logic       v2, c2, ovf2, st2;

  obs_t obs [3];
  obs_t exp_o [3];
  ent_t sb [3][$];
  logic [7:0] m_acc [3];
  logic [7:0] m_cnt [3];
  logic       pend_v = 1'b0;
  logic [1:0] m_opr = 2'd0;
  logic [7:0] m_a = 8'd0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  accum_unit #(.WIDTH(8), .CNT_W(8), .SATURATE(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .in(din), .ovf_clr(ovf_clr),
    .a_reg(a0), .acc_out(acc0), .preview(pv0), .out_valid(v0), .carry(c0),
    .overflow(ovf0), .ovf_sticky(st0), .count(cnt0));

  accum_unit #(.WIDTH(8), .CNT_W(8), .SATURATE(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .in(din), .ovf_clr(ovf_clr),
    .a_reg(a1), .acc_out(acc1), .preview(pv1), .out_valid(v1), .carry(c1),
    .overflow(ovf1), .ovf_sticky(st1), .count(cnt1));

  accum_unit #(.WIDTH(8), .CNT_W(2), .SATURATE(0)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op), .in(din), .ovf_clr(ovf_clr),
    .a_reg(a2), .acc_out(acc2), .preview(pv2), .out_valid(v2), .carry(c2),
    .overflow(ovf2), .ovf_sticky(st2), .count(cnt2));

  // Gather each instance's outputs into one comparable word.
  always_comb begin
    obs[0] = {v0, a0, acc0, c0, ovf0, st0, cnt0, pv0};
    obs[1] = {v1, a1, acc1, c1, ovf1, st1, cnt1, pv1};
    obs[2] = {v2, a2, acc2, c2, ovf2, st2, {6'd0, cnt2}, pv2};
  end

  function automatic stim_t mk(input logic v, input logic [1:0] o, input logic [7:0] d,
                               input logic clr, input logic rs);
    stim_t s;
    s.v = v; s.o = o; s.d = d; s.clr = clr; s.rs = rs;
    return s;
  endfunction

  function automatic stim_t opv(input logic [1:0] o, input logic [7:0] d);
    return mk(1'b1, o, d, 1'b0, 1'b1);
  endfunction

  function automatic stim_t idle(input logic clr);
    return mk(1'b0, OP_ADD, 8'h00, clr, 1'b1);
  endfunction

  // Unclamped result of op on acc/a, low 8 bits.
  function automatic logic [7:0] pv_of(input logic [7:0] acc, input logic [7:0] a, input logic [1:0] o);
    int t;
    case (o)
      OP_ADD:  t = int'(acc) + int'(a);
      OP_SUB:  t = int'(acc) - int'(a);
      OP_LOAD: t = int'(a);
      default: t = 0;
    endcase
    return t[7:0];
  endfunction

  // Drive one cycle of stimulus and advance the reference model across the edge.
  task automatic tick(input stim_t s);
    ent_t e;
    int ua, ub, ur, sa, sbv, sr, cmax;
    in_valid = s.v; op = s.o; din = s.d; ovf_clr = s.clr; reset = s.rs;
    @(posedge clock);
    if (!s.rs) begin
      for (int k = 0; k < 3; k++) begin
        sb[k].delete();
        m_acc[k] = 8'd0;
        m_cnt[k] = 8'd0;
        exp_o[k] = '0;
      end
      pend_v = 1'b0; m_opr = 2'd0; m_a = 8'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp_o[k].ov = pend_v;
        if (pend_v && sb[k].size() > 0) begin
          e = sb[k].pop_front();
          exp_o[k].acc = e.acc; exp_o[k].c = e.c; exp_o[k].ovf = e.ovf; exp_o[k].cnt = e.cnt;
          if (e.ovf) exp_o[k].st = 1'b1;
          else if (e.op == OP_CLR) exp_o[k].st = 1'b0;
          else if (s.clr) exp_o[k].st = 1'b0;
        end else if (s.clr) begin
          exp_o[k].st = 1'b0;
        end
      end
      if (s.v) begin
        for (int k = 0; k < 3; k++) begin
          ua = int'(m_acc[k]); ub = int'(s.d);
          sa = int'($signed(m_acc[k])); sbv = int'($signed(s.d));
          e.c = 1'b0;
          case (s.o)
            OP_ADD:  begin ur = ua + ub; sr = sa + sbv; e.c = (ur > 255); end
            OP_SUB:  begin ur = ua - ub; sr = sa - sbv; e.c = (ua < ub); end
            OP_LOAD: begin ur = ub; sr = 0; end
            default: begin ur = 0; sr = 0; end
          endcase
          e.ovf = (sr > 127) || (sr < -128);
          e.acc = ur[7:0];
          if (k == 1 && e.ovf) e.acc = (sa < 0) ? 8'h80 : 8'h7F;
          cmax = (k == 2) ? 3 : 255;
          case (s.o)
            OP_ADD, OP_SUB: if (int'(m_cnt[k]) < cmax) m_cnt[k] = m_cnt[k] + 8'd1;
            OP_LOAD: m_cnt[k] = 8'd1;
            default: m_cnt[k] = 8'd0;
          endcase
          e.cnt = m_cnt[k];
          e.op = s.o;
          m_acc[k] = e.acc;
          sb[k].push_back(e);
        end
        m_a = s.d; m_opr = s.o;
      end
      pend_v = s.v;
    end
    for (int k = 0; k < 3; k++) begin
      exp_o[k].a = m_a;
      exp_o[k].pv = pv_of(exp_o[k].acc, m_a, m_opr);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    stim_t t[5];
    t = '{mk(1'b1, OP_ADD, 8'hAA, 1'b0, 1'b0), mk(1'b1, OP_ADD, 8'hAA, 1'b0, 1'b0),
          idle(1'b0), idle(1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL reset[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      n_chk++;
      if (acc0 !== 8'h00 || a0 !== 8'h00 || v0 !== 1'b0 || cnt0 !== 8'h00)
        $display("FAIL reset_zero[%0d]: acc=%h a=%h ov=%b cnt=%h want 00 00 0 00", i, acc0, a0, v0, cnt0);
      else n_pass++;
    end
  endtask

  task automatic test_add();
    stim_t t[4];
    t = '{opv(OP_ADD, 8'h05), opv(OP_ADD, 8'h03), idle(1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL add[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      if (i == 2) begin
        n_chk++;
        if (acc0 !== 8'h08 || cnt0 !== 8'd2 || c0 !== 1'b0 || ovf0 !== 1'b0 || v0 !== 1'b1)
          $display("FAIL add_b2b: acc=%h cnt=%h c=%b ovf=%b ov=%b want 08 02 0 0 1", acc0, cnt0, c0, ovf0, v0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    stim_t t[4];
    t = '{opv(OP_LOAD, 8'h70), opv(OP_ADD, 8'h20), idle(1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL ovf[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      if (i == 2) begin
        n_chk++;
        if (acc0 !== 8'h90 || ovf0 !== 1'b1 || st0 !== 1'b1 || c0 !== 1'b0 || acc1 !== 8'h7F || ovf1 !== 1'b1)
          $display("FAIL ovf_add: acc0=%h ovf0=%b st0=%b c0=%b acc1=%h ovf1=%b want 90 1 1 0 7f 1",
                   acc0, ovf0, st0, c0, acc1, ovf1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sub();
    stim_t t[7];
    t = '{opv(OP_LOAD, 8'h05), opv(OP_SUB, 8'h07), idle(1'b0),
          opv(OP_LOAD, 8'h80), opv(OP_SUB, 8'h01), idle(1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL sub[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      if (i == 2) begin
        n_chk++;
        if (acc0 !== 8'hFE || c0 !== 1'b1 || ovf0 !== 1'b0)
          $display("FAIL sub_borrow: acc=%h c=%b ovf=%b want fe 1 0", acc0, c0, ovf0);
        else n_pass++;
      end
      if (i == 5) begin
        n_chk++;
        if (acc0 !== 8'h7F || ovf0 !== 1'b1 || acc1 !== 8'h80)
          $display("FAIL sub_ovf: acc0=%h ovf0=%b acc1=%h want 7f 1 80", acc0, ovf0, acc1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sticky();
    stim_t t[11];
    t = '{opv(OP_LOAD, 8'h70), opv(OP_ADD, 8'h70), opv(OP_LOAD, 8'h70), opv(OP_ADD, 8'h70),
          idle(1'b1), idle(1'b1), opv(OP_LOAD, 8'h70), opv(OP_ADD, 8'h70),
          opv(OP_CLR, 8'h00), idle(1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL sticky[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      if (i == 4 || i == 5 || i == 9) begin
        n_chk++;
        if (st0 !== (i == 4) || st1 !== (i == 4))
          $display("FAIL sticky_flag[%0d]: st0=%b st1=%b want %b", i, st0, st1, (i == 4));
        else n_pass++;
      end
      if (i == 9) begin
        n_chk++;
        if (acc0 !== 8'h00 || cnt0 !== 8'h00 || v0 !== 1'b1)
          $display("FAIL clr_op: acc=%h cnt=%h ov=%b want 00 00 1", acc0, cnt0, v0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_count_sat();
    stim_t t[11];
    t = '{opv(OP_LOAD, 8'h01), opv(OP_ADD, 8'h01), opv(OP_ADD, 8'h01), opv(OP_ADD, 8'h01),
          opv(OP_ADD, 8'h01), opv(OP_ADD, 8'h01), idle(1'b0), idle(1'b0),
          opv(OP_ADD, 8'h01), mk(1'b0, OP_ADD, 8'h00, 1'b0, 1'b0), idle(1'b0)};
    foreach (t[i]) begin
      tick(t[i]);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL count[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
      if (i == 6) begin
        n_chk++;
        if (acc2 !== 8'h06 || cnt2 !== 2'd3 || cnt0 !== 8'd6)
          $display("FAIL count_sat: acc2=%h cnt2=%0d cnt0=%0d want 06 3 6", acc2, cnt2, cnt0);
        else n_pass++;
      end
      if (i >= 9) begin
        n_chk++;
        if (acc2 !== 8'h00 || v2 !== 1'b0 || acc0 !== 8'h00 || v0 !== 1'b0)
          $display("FAIL mid_reset[%0d]: acc2=%h ov2=%b acc0=%h ov0=%b want 00 0 00 0", i, acc2, v2, acc0, v0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 80; i++) begin
      s = mk($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             $urandom_range(0, 7) == 0, 1'b1);
      tick(s);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs[k] !== exp_o[k]) $display("FAIL random[%0d] dut%0d: got %h want %h", i, k, obs[k], exp_o[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 8'd0;
      m_cnt[k] = 8'd0;
      exp_o[k] = '0;
    end
    @(negedge clock);
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_sticky();
    test_count_sat();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/accum_unit.md
Name: accum_unit

Overview:
Parametrised successor to the board-level 8-bit accumulator. The input is registered, then combined with the running total as add, subtract, load or clear. Signed overflow can wrap or saturate, and the block keeps a sticky overflow flag and a saturating sample counter. It sits behind the switch/key front end and drives the seven-segment and LED display logic, and it is also reused as a generic datapath accumulator.

Parameters:
WIDTH, 8, data width of operand and accumulator (>=2)
CNT_W, 8, width of accepted-sample counter (>=1)
SATURATE, 0, 1 = clamp on signed overflow, 0 = two's-complement wrap

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  operand/op accepted this edge when high
op  input  2  0=ADD, 1=SUB, 2=LOAD, 3=CLR
in  input  WIDTH  operand
ovf_clr  input  1  clears ovf_sticky
a_reg  output  WIDTH  registered operand (display copy)
acc_out  output  WIDTH  accumulator register
preview  output  WIDTH  combinational result of pending op on acc_out/a_reg, pre-saturation (LED preview)
out_valid  output  1  one-cycle pulse: acc_out updated on previous edge
carry  output  1  ADD carry-out / SUB borrow of last executed op
overflow  output  1  signed overflow of last executed op
ovf_sticky  output  1  set by any overflow, held until cleared
count  output  CNT_W  number of operands folded in since last LOAD/CLR

Behaviour:
- Reset (reset==0 at rising edge): a_reg, acc_out, count, carry, overflow, ovf_sticky, out_valid, and the internal stage-1 valid/op all go to 0. in_valid during reset is ignored. A reset mid-pipeline discards the pending operand.
- Stage 1, every edge: s1_v <= in_valid. If in_valid, a_reg <= in and op_r <= op; otherwise a_reg holds.
- Stage 2, at the edge where s1_v==1, op_r decides the update:
  - ADD: {c,r} = acc_out + a_reg (WIDTH+1 bits). ovf = sign(acc)==sign(a) && sign(r)!=sign(acc).
  - SUB: r = acc_out - a_reg. c = 1 when acc_out < a_reg (unsigned borrow). ovf = sign(acc)!=sign(a) && sign(r)!=sign(acc).
  - LOAD: r = a_reg, c = 0, ovf = 0, count <= 1.
  - CLR: r = 0, c = 0, ovf = 0, count <= 0, ovf_sticky <= 0.
  - If SATURATE==1 and ovf: r = 0x7F.. when sign(acc)==0, else 0x80... With SATURATE==0, r wraps.
  - acc_out <= r, carry <= c, overflow <= ovf, out_valid <= 1.
  - ADD/SUB: count <= count+1, saturating at all-ones with no wrap.
- When s1_v==0: acc_out, carry, overflow and count hold; out_valid <= 0.
- Latency: operand on edge N, acc_out on edge N+1, out_valid high for the cycle after N+1. Back-to-back in_valid sustains one op per cycle. There is no backpressure.
- ovf_sticky: set when a stage-2 op has ovf==1. Cleared by ovf_clr or CLR.
  - Set and ovf_clr on the same edge: set wins, sticky=1.
  - CLR: never overflows, so sticky=0.
- preview = low WIDTH bits of the raw ADD/SUB result for op_r. It equals a_reg for LOAD and 0 for CLR.

Decomposition:
- Shared package accum_pkg:
  - op encodings OP_ADD, OP_SUB, OP_LOAD, OP_CLR, and the 2-bit op type.
  - functions/constants for signed max/min given WIDTH.
- One natural sub-module, accum_addsub: combinational. Takes acc, a, op, SATURATE and returns r_raw, r_sat, c, ovf. It is shared by the preview and stage-2 paths.
- The top holds all registers and counters.

Test Plan:
1. reset=0 for 2 edges with in_valid=1, in=0xAA -> all outputs 0, no out_valid pulse. Release, idle 3 cycles -> outputs hold 0.
2. WIDTH=8: ADD 0x05 then ADD 0x03 back-to-back -> acc_out 0x05 then 0x08, out_valid two consecutive pulses, count=2, carry=0, overflow=0.
3. LOAD 0x70, ADD 0x20:
   - SATURATE=0 -> acc 0x90, overflow=1, ovf_sticky=1, carry=0.
   - SATURATE=1 -> acc 0x7F, overflow=1.
4. LOAD 0x05, SUB 0x07 -> acc 0xFE, carry(borrow)=1, overflow=0. Then LOAD 0x80, SUB 0x01:
   - SATURATE=0 -> acc 0x7F, overflow=1.
   - SATURATE=1 -> acc 0x80.
5. Cause overflow, then assert ovf_clr on the same edge as another overflowing ADD -> ovf_sticky stays 1. Next edge ovf_clr alone -> 0. CLR op also clears it and sets acc=0, count=0.
6. CNT_W=2: LOAD then 5 ADDs of 0x01 -> count 1,2,3,3,3,3 and acc 0x06. Reset asserted between stage 1 and stage 2 of an ADD -> acc 0, no out_valid.
